// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> atan2(y, x) in Q3.19 and magnitude in Q4.20.
// Define CORDIC_GAIN_COMP_EN to add the GAIN state that scales the magnitude by 1/K.
module cordic_vectoring #(
    parameter int WIDTH = 22,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-1:0] angle_out,
    output logic [WIDTH+1:0] mag_out,
    output logic             busy,
    output logic             done
);
    localparam int XW = WIDTH + 2;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic signed [WIDTH-1:0] PI_Q = WIDTH'(1647099);
`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [21:0] KGAIN = 22'sd636752;
`endif

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_GAIN} state_t;

    state_t                  state_q, state_d;
    logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    logic [CW-1:0]           i_q, i_d;
    logic                    zero_q, zero_d;
    logic [WIDTH-1:0]        angle_q, angle_d;
    logic [XW-1:0]           mag_q, mag_d;
    logic                    done_q, done_d;

    logic signed [XW-1:0]    x_sh, y_sh, x_it, y_it;
    logic signed [WIDTH-1:0] z_it, atan_i;
`ifdef CORDIC_GAIN_COMP_EN
    logic signed [XW+21:0]   prod;
`endif

    // round(atan(2^-i) * 2^19)
    function automatic logic signed [WIDTH-1:0] atan_lut(input int idx);
        case (idx)
            0:  atan_lut = WIDTH'(411775);
            1:  atan_lut = WIDTH'(243085);
            2:  atan_lut = WIDTH'(128439);
            3:  atan_lut = WIDTH'(65198);
            4:  atan_lut = WIDTH'(32725);
            5:  atan_lut = WIDTH'(16379);
            6:  atan_lut = WIDTH'(8191);
            7:  atan_lut = WIDTH'(4096);
            8:  atan_lut = WIDTH'(2048);
            9:  atan_lut = WIDTH'(1024);
            10: atan_lut = WIDTH'(512);
            11: atan_lut = WIDTH'(256);
            12: atan_lut = WIDTH'(128);
            13: atan_lut = WIDTH'(64);
            14: atan_lut = WIDTH'(32);
            15: atan_lut = WIDTH'(16);
            16: atan_lut = WIDTH'(8);
            17: atan_lut = WIDTH'(4);
            18: atan_lut = WIDTH'(2);
            19: atan_lut = WIDTH'(1);
            default: atan_lut = '0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        mag_d   = mag_q;
        done_d  = 1'b0;

        x_sh   = x_q >>> i_q;
        y_sh   = y_q >>> i_q;
        atan_i = atan_lut(int'(i_q));
        if (!y_q[XW-1]) begin
            x_it = x_q + y_sh;
            y_it = y_q - x_sh;
            z_it = z_q + atan_i;
        end else begin
            x_it = x_q - y_sh;
            y_it = y_q + x_sh;
            z_it = z_q - atan_i;
        end
`ifdef CORDIC_GAIN_COMP_EN
        prod = (XW+22)'(x_q) * (XW+22)'(KGAIN);
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = XW'($signed(x_in));
                    y_d     = XW'($signed(y_in));
                    zero_d  = (x_in == '0) && (y_in == '0);
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                // Fold the left half-plane onto the right so the iterations converge.
                if (x_q[XW-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = y_q[XW-1] ? -PI_Q : PI_Q;
                end else begin
                    z_d = '0;
                end
                i_d     = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                x_d = x_it;
                y_d = y_it;
                z_d = z_it;
                i_d = i_q + CW'(1);
                if (i_q == CW'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = S_GAIN;
`else
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    angle_d = zero_q ? '0 : z_it;
                    mag_d   = zero_q ? '0 : x_it;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_GAIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                angle_d = zero_q ? '0 : z_q;
                mag_d   = zero_q ? '0 : XW'(prod >>> 20);
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
            done_q  <= done_d;
        end
    end

    assign angle_out = angle_q;
    assign mag_out   = mag_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
endmodule
